// File: rtl/stream_rr_share.sv
// Round-robin sharing of one in-order stream datapath between N requesters.
// A tag FIFO records the owner of each issued token so results route back to it.
module stream_rr_share #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N*W-1:0]               req_data,
    input  logic [N-1:0]                 req_valid,
    output logic [N-1:0]                 req_ready,
    output logic [W-1:0]                 dp_in_data,
    output logic                         dp_in_valid,
    input  logic                         dp_in_ready,
    input  logic [W-1:0]                 dp_out_data,
    input  logic                         dp_out_valid,
    output logic                         dp_out_ready,
    output logic [W-1:0]                 rsp_data,
    output logic [N-1:0]                 rsp_valid,
    input  logic [N-1:0]                 rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] ptr, g, h;
    logic [PW-1:0] tags [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          any_req, full, empty, issue, ret;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin : grant
        int j;
        g       = '0;
        any_req = 1'b0;
        j       = 0;
        for (int k = N-1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req_valid[j]) begin
                g       = PW'(j);
                any_req = 1'b1;
            end
        end
    end

    assign full  = (outstanding == CW'(DEPTH));
    assign empty = (outstanding == '0);
    assign h     = tags[rd_ptr];

    assign dp_in_valid  = !rst && any_req && !full;
    assign dp_in_data   = req_data[int'(g)*W +: W];
    assign req_ready    = (!rst && any_req && dp_in_ready && !full) ? (N'(1) << g) : '0;
    assign issue        = dp_in_valid && dp_in_ready;

    assign dp_out_ready = !rst && !empty && rsp_ready[h];
    assign rsp_valid    = (!rst && dp_out_valid && !empty) ? (N'(1) << h) : '0;
    assign rsp_data     = dp_out_data;
    assign ret          = dp_out_valid && dp_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
                ptr    <= (g == PW'(N-1)) ? '0 : g + PW'(1);
            end
            if (ret)
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            case ({issue, ret})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            // A result with nothing in flight has no owner; flag it and leave it unacknowledged.
            if (dp_out_valid && empty)
                err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (issue)
            tags[wr_ptr] <= g;
    end
endmodule

// File: tb/tb_stream_rr_share.sv
// Randomized scoreboard bench for stream_rr_share with an echo datapath model.
module tb_stream_rr_share;
    localparam int N = 2, W = 8, DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0, req_ready;
    logic [W-1:0]   dp_in_data;
    logic           dp_in_valid;
    logic           dp_in_ready = 1'b0;
    logic [W-1:0]   dp_out_data = '0;
    logic           dp_out_valid = 1'b0;
    logic           dp_out_ready;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [2:0]     outstanding;
    logic           err;

    stream_rr_share #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .dp_in_data(dp_in_data), .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
        .dp_out_data(dp_out_data), .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (owned by the monitor)
    int         mptr = 0, mcnt = 0;
    bit         merr = 0;
    int         own_q[$];
    logic [7:0] dp_q[$];
    logic [7:0] iss_log[$];
    logic [N-1:0] acc_vec = '0;
    // Scoreboard: expected results per requester, pushed when a token is offered
    logic [7:0] exp_q[N][$];

    // Driver state
    logic [N-1:0] hv = '0;
    logic [7:0]   htok[N];
    logic [7:0]   base[N];
    int           seq[N];
    logic [N-1:0] en_req = '0;
    bit           use_seq = 0, force_dov = 0;
    int           budget = 0, p_req = 0, p_dinr = 0, p_rspr = 0;

    always @(negedge clk) begin : mon
        int eg, o;
        bit any, can, mis, mret;
        logic [N-1:0] exp_rv;
        #1;
        if (rst) begin
            mptr = 0; mcnt = 0; merr = 0; acc_vec = '0;
            own_q.delete(); dp_q.delete();
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            any = |req_valid;
            eg = 0;
            for (int k = N-1; k >= 0; k--)
                if (req_valid[(mptr+k)%N]) eg = (mptr+k)%N;
            can = any && (mcnt < DEPTH);
            chk("dp_in_valid", 32'(dp_in_valid), 32'(can));
            chk("req_ready", 32'(req_ready), (can && dp_in_ready) ? 32'(1 << eg) : 32'd0);
            if (can) chk("dp_in_data", 32'(dp_in_data), 32'(htok[eg]));
            chk("outstanding", 32'(outstanding), 32'(mcnt));
            chk("err", 32'(err), 32'(merr));
            exp_rv = (dp_out_valid && own_q.size() > 0) ? N'(1 << own_q[0]) : '0;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            mret = (exp_rv != '0) && rsp_ready[own_q[0]];
            chk("dp_out_ready", 32'(dp_out_ready), 32'(mret));
            for (int i = 0; i < N; i++)
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL rsp_unexpected: requester %0d got %0h expected none", i, rsp_data);
                    end else
                        chk("rsp_data", 32'(rsp_data), 32'(exp_q[i].pop_front()));
                end
            if (dp_out_valid && mcnt == 0) merr = 1;
            mis = can && dp_in_ready;
            acc_vec = mis ? N'(1 << eg) : '0;
            if (mret) begin
                o = own_q.pop_front();
                void'(dp_q.pop_front());
            end
            if (mis) begin
                own_q.push_back(eg);
                dp_q.push_back(htok[eg]);
                iss_log.push_back(htok[eg]);
                mptr = (eg + 1) % N;
            end
            mcnt = mcnt + int'(mis) - int'(mret);
        end
    end

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc_vec[i]) hv[i] = 1'b0;
            if (!hv[i] && en_req[i] && budget > 0 && $urandom_range(99) < p_req) begin
                htok[i] = use_seq ? base[i] + 8'(seq[i]) : 8'($urandom);
                seq[i]++;
                hv[i] = 1'b1;
                exp_q[i].push_back(htok[i]);
                budget--;
            end
            req_data[i*W +: W] = htok[i];
            rsp_ready[i] = ($urandom_range(99) < p_rspr);
        end
        req_valid    = hv;
        dp_in_ready  = ($urandom_range(99) < p_dinr);
        dp_out_valid = force_dov || (dp_q.size() > 0);
        dp_out_data  = (dp_q.size() > 0) ? dp_q[0] : 8'($urandom);
    endtask

    task automatic setup(input logic [N-1:0] en, input bit sq, input int bud,
                         input int pr, input int pd, input int ps);
        en_req = en; use_seq = sq; budget = bud;
        p_req = pr; p_dinr = pd; p_rspr = ps;
        for (int i = 0; i < N; i++) seq[i] = 0;
    endtask

    task automatic drain();
        int t;
        setup('0, 0, 0, 0, 100, 100);
        t = 0;
        while ((mcnt != 0 || hv != '0) && t < 200) begin
            cycle();
            t++;
        end
        cycle(); #2;
        chk("drain_timeout", 32'(t < 200), 32'd1);
        for (int i = 0; i < N; i++) chk("scoreboard_empty", 32'(exp_q[i].size()), 32'd0);
    endtask

    initial begin : main
        int s, pk;
        logic r1;
        for (int i = 0; i < N; i++) begin htok[i] = '0; base[i] = '0; seq[i] = 0; end
        // Reset outputs with all inputs asserting
        #12;
        req_valid = '1; dp_in_ready = 1'b1; dp_out_valid = 1'b1; rsp_ready = '1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_in_valid", 32'(dp_in_valid), 32'd0);
        chk("rst_dp_out_ready", 32'(dp_out_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        req_valid = '0; dp_in_ready = 1'b0; dp_out_valid = 1'b0; rsp_ready = '0;
        rst = 1'b0;

        // Contention from reset pointer: expect 10,20,11,21
        base[0] = 8'h10; base[1] = 8'h20;
        setup(2'b11, 1, 4, 100, 100, 100);
        s = iss_log.size();
        repeat (10) cycle();
        if (iss_log.size() < s + 4) begin
            n_checks++; n_err++;
            $display("FAIL contention_count: got %0d issues expected 4", iss_log.size() - s);
        end else begin
            chk("contention_0", 32'(iss_log[s]),   32'h10);
            chk("contention_1", 32'(iss_log[s+1]), 32'h20);
            chk("contention_2", 32'(iss_log[s+2]), 32'h11);
            chk("contention_3", 32'(iss_log[s+3]), 32'h21);
        end
        drain();

        // Single requester, tokens 5,6,7
        base[0] = 8'd5;
        setup(2'b01, 1, 3, 100, 100, 100);
        pk = 0; r1 = 1'b0;
        repeat (8) begin
            cycle(); #2;
            if (int'(outstanding) > pk) pk = int'(outstanding);
            r1 = r1 | rsp_valid[1];
        end
        chk("single_peak", 32'(pk), 32'd1);
        chk("single_rsp1", 32'(r1), 32'd0);
        drain();

        // Full stall: 6 offered, 4 issue
        setup(2'b11, 0, 6, 100, 100, 0);
        s = iss_log.size();
        repeat (10) cycle();
        #2;
        chk("full_outstanding", 32'(outstanding), 32'd4);
        chk("full_dp_in_valid", 32'(dp_in_valid), 32'd0);
        chk("full_issued", 32'(iss_log.size() - s), 32'd4);
        p_rspr = 100;
        repeat (10) cycle();
        drain();

        // Random traffic with back-pressure on every interface
        setup(2'b11, 0, 100000, 60, 70, 70);
        repeat (1500) cycle();
        drain();

        // Result with nothing in flight
        force_dov = 1;
        cycle(); #2;
        chk("err_dp_out_ready", 32'(dp_out_ready), 32'd0);
        force_dov = 0;
        cycle(); #2;
        chk("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset with three in flight
        setup(2'b01, 0, 3, 100, 100, 0);
        repeat (6) cycle();
        #2;
        chk("burst_outstanding", 32'(outstanding), 32'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_outstanding", 32'(outstanding), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        hv = '0;
        setup('0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        #3;
        rst = 1'b0;

        setup(2'b11, 0, 100000, 70, 80, 60);
        repeat (300) cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
